// File: rtl/morse_char_sequencer_if.sv
// Byte intake, generator handshake and status strobes of the Morse character sequencer.
// The sequencer takes the slave side; whatever drives bytes and answers the generator takes master.
interface morse_char_sequencer_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       i_Done;
  logic       o_Start;
  logic [4:0] o_Morse_Pattern;
  logic [2:0] o_Morse_Length;
  logic       o_Busy;
  logic       o_Overflow;
  logic       o_Bad_Char;

  modport master (
    output i_RX_DV, i_RX_Byte, i_Done,
    input  o_Start, o_Morse_Pattern, o_Morse_Length, o_Busy, o_Overflow, o_Bad_Char
  );

  modport slave (
    input  i_RX_DV, i_RX_Byte, i_Done,
    output o_Start, o_Morse_Pattern, o_Morse_Length, o_Busy, o_Overflow, o_Bad_Char
  );
endinterface

// File: rtl/morse_char_sequencer.sv
// Buffers ASCII bytes, maps each to a Morse dot/dash pattern and paces the signal generator
// one character at a time, inserting character and word silences between them.
module morse_char_sequencer #(
  parameter int UNIT_CYCLES    = 2500000,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                    i_Clock,
  input  logic                    i_Rst_L,
  morse_char_sequencer_if.slave   bus
);

  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = AW + 1;
  localparam int CHAR_GAP_CYC = CHAR_GAP_UNITS * UNIT_CYCLES;
  localparam int WORD_GAP_CYC = WORD_GAP_UNITS * UNIT_CYCLES;
  localparam int GAP_MAX      = (WORD_GAP_CYC > CHAR_GAP_CYC) ? WORD_GAP_CYC : CHAR_GAP_CYC;
  localparam int GW           = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_DONE, GAP} state_t;
  typedef enum logic [1:0] {CK_SYM, CK_SPACE, CK_BAD} char_kind_t;

  typedef struct packed {
    char_kind_t kind;
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  function automatic code_t sym(input logic [2:0] l, input logic [4:0] p);
    code_t r;
    r = '{CK_SYM, l, p};
    return r;
  endfunction

  // Pattern bit k is element k (bit 0 sent first), 1 = dash.
  function automatic code_t decode_char(input logic [7:0] c);
    code_t      r;
    logic [7:0] u;
    r = '{CK_BAD, 3'd0, 5'd0};
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    case (u)
      "A": r = sym(3'd2, 5'b00010);
      "B": r = sym(3'd4, 5'b00001);
      "C": r = sym(3'd4, 5'b00101);
      "D": r = sym(3'd3, 5'b00001);
      "E": r = sym(3'd1, 5'b00000);
      "F": r = sym(3'd4, 5'b00100);
      "G": r = sym(3'd3, 5'b00011);
      "H": r = sym(3'd4, 5'b00000);
      "I": r = sym(3'd2, 5'b00000);
      "J": r = sym(3'd4, 5'b01110);
      "K": r = sym(3'd3, 5'b00101);
      "L": r = sym(3'd4, 5'b00010);
      "M": r = sym(3'd2, 5'b00011);
      "N": r = sym(3'd2, 5'b00001);
      "O": r = sym(3'd3, 5'b00111);
      "P": r = sym(3'd4, 5'b00110);
      "Q": r = sym(3'd4, 5'b01011);
      "R": r = sym(3'd3, 5'b00010);
      "S": r = sym(3'd3, 5'b00000);
      "T": r = sym(3'd1, 5'b00001);
      "U": r = sym(3'd3, 5'b00100);
      "V": r = sym(3'd4, 5'b01000);
      "W": r = sym(3'd3, 5'b00110);
      "X": r = sym(3'd4, 5'b01001);
      "Y": r = sym(3'd4, 5'b01101);
      "Z": r = sym(3'd4, 5'b00011);
      "0": r = sym(3'd5, 5'b11111);
      "1": r = sym(3'd5, 5'b11110);
      "2": r = sym(3'd5, 5'b11100);
      "3": r = sym(3'd5, 5'b11000);
      "4": r = sym(3'd5, 5'b10000);
      "5": r = sym(3'd5, 5'b00000);
      "6": r = sym(3'd5, 5'b00001);
      "7": r = sym(3'd5, 5'b00011);
      "8": r = sym(3'd5, 5'b00111);
      "9": r = sym(3'd5, 5'b01111);
      8'h20: r = '{CK_SPACE, 3'd0, 5'd0};
      default: r = '{CK_BAD, 3'd0, 5'd0};
    endcase
    return r;
  endfunction

  state_t          state, state_nxt;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            push, pop, overflow_d;
  logic [7:0]      cur_byte;
  code_t           cur_code;
  logic [GW-1:0]   gap_cnt;
  logic            start_d, bad_d, load_sym, load_char_gap, load_word_gap;

  // Fullness is judged on the pre-edge count, so a simultaneous pop never rescues a push at full.
  always_comb begin
    push       = bus.i_RX_DV && (count < CW'(FIFO_DEPTH));
    overflow_d = bus.i_RX_DV && !(count < CW'(FIFO_DEPTH));
    pop        = (state == IDLE) && (count != '0);
    count_nxt  = count + CW'(push) - CW'(pop);
    cur_code   = decode_char(cur_byte);
  end

  always_ff @(posedge i_Clock) begin
    if (push) fifo_mem[wr_ptr] <= bus.i_RX_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (pop) cur_byte <= fifo_mem[rd_ptr];
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // FSM: state register
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (count != '0) state_nxt = LOAD;
      LOAD: begin
        case (cur_code.kind)
          CK_SYM:   state_nxt = SEND;
          CK_SPACE: state_nxt = GAP;
          default:  state_nxt = IDLE;
        endcase
      end
      SEND:      state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.i_Done) state_nxt = GAP;
      GAP:       if (gap_cnt <= GW'(1)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM: outputs, registered below so every strobe is a clean one-cycle pulse
  always_comb begin
    start_d       = (state == SEND);
    bad_d         = (state == LOAD) && (cur_code.kind == CK_BAD);
    load_sym      = (state == LOAD) && (cur_code.kind == CK_SYM);
    load_word_gap = (state == LOAD) && (cur_code.kind == CK_SPACE);
    load_char_gap = (state == WAIT_DONE) && bus.i_Done;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      gap_cnt <= '0;
    end else if (load_word_gap) begin
      gap_cnt <= GW'(WORD_GAP_CYC);
    end else if (load_char_gap) begin
      gap_cnt <= GW'(CHAR_GAP_CYC);
    end else if (state == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // Pattern and length only change in LOAD, so they stay stable through WAIT_DONE.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bus.o_Start         <= 1'b0;
      bus.o_Morse_Pattern <= '0;
      bus.o_Morse_Length  <= '0;
      bus.o_Busy          <= 1'b0;
      bus.o_Overflow      <= 1'b0;
      bus.o_Bad_Char      <= 1'b0;
    end else begin
      bus.o_Start    <= start_d;
      bus.o_Overflow <= overflow_d;
      bus.o_Bad_Char <= bad_d;
      bus.o_Busy     <= (state_nxt != IDLE) || (count_nxt != '0);
      if (load_sym) begin
        bus.o_Morse_Pattern <= cur_code.pat;
        bus.o_Morse_Length  <= cur_code.len;
      end
    end
  end

endmodule

// File: tb/tb_morse_char_sequencer.sv
// Directed bench for morse_char_sequencer with a 10-clock Morse unit.
module tb_morse_char_sequencer;
  localparam int UNIT = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  morse_char_sequencer_if bus();

  morse_char_sequencer #(
    .UNIT_CYCLES(UNIT), .CHAR_GAP_UNITS(3), .WORD_GAP_UNITS(7), .FIFO_DEPTH(16)
  ) dut (
    .i_Clock(clk),
    .i_Rst_L(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int ovf_cnt = 0;
  int bad_cnt = 0;
  int fall_cyc = 0;
  logic [4:0] start_pat = '0;
  logic [2:0] start_len = '0;
  logic busy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder; cyc here is the index of the rising edge that produced the value.
  always @(negedge clk) begin
    if (bus.o_Start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
      start_pat = bus.o_Morse_Pattern;
      start_len = bus.o_Morse_Length;
    end
    if (bus.o_Overflow) ovf_cnt = ovf_cnt + 1;
    if (bus.o_Bad_Char) bad_cnt = bad_cnt + 1;
    if (busy_q && !bus.o_Busy) fall_cyc = cyc;
    busy_q = bus.o_Busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output int wc);
    bus.i_RX_DV   = 1'b1;
    bus.i_RX_Byte = b;
    tick();
    bus.i_RX_DV   = 1'b0;
    wc = cyc;
  endtask

  task automatic pulse_done(output int dc);
    bus.i_Done = 1'b1;
    tick();
    bus.i_Done = 1'b0;
    dc = cyc;
  endtask

  task automatic wait_start(input int base, input int maxc, input string tag);
    int n = 0;
    while (start_cnt <= base && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 32'(start_cnt > base), 32'd1);
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    while (bus.o_Busy && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.o_Busy), 32'd0);
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, "_start"}, 32'(bus.o_Start), 32'd0);
    chk({tag, "_pat"},   32'(bus.o_Morse_Pattern), 32'd0);
    chk({tag, "_len"},   32'(bus.o_Morse_Length), 32'd0);
    chk({tag, "_busy"},  32'(bus.o_Busy), 32'd0);
    chk({tag, "_ovf"},   32'(bus.o_Overflow), 32'd0);
    chk({tag, "_bad"},   32'(bus.o_Bad_Char), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, bb, ob, wc, dc;
    rst_n = 1'b0;
    bus.i_RX_DV = 1'b0;
    bus.i_RX_Byte = '0;
    bus.i_Done = 1'b0;
    repeat (3) tick();
    chk_outputs_reset("por");
    rst_n = 1'b1;
    tick();

    // Single 'F': start three clocks after the write, idle 30 clocks after done.
    b = start_cnt;
    send("F", wc);
    wait_start(b, 20, "f_seen");
    chk("f_latency", start_cyc - wc, 3);
    chk("f_pat", 32'(start_pat), 32'b00100);
    chk("f_len", 32'(start_len), 4);
    chk("f_busy", 32'(bus.o_Busy), 1);
    pulse_done(dc);
    wait_idle(100, "f_idle");
    chk("f_busy_fall", fall_cyc - dc, 30);
    chk("f_one_start", start_cnt - b, 1);

    // "ET": second start 33 clocks after the first done.
    b = start_cnt;
    send("E", wc);
    send("T", wc);
    wait_start(b, 20, "e_seen");
    chk("e_pat", 32'(start_pat), 0);
    chk("e_len", 32'(start_len), 1);
    pulse_done(dc);
    wait_start(b + 1, 60, "t_seen");
    chk("et_spacing", start_cyc - dc, 33);
    chk("t_pat", 32'(start_pat), 32'b00001);
    chk("t_len", 32'(start_len), 1);
    pulse_done(dc);
    wait_idle(100, "et_idle");

    // "E T": 30 char gap, IDLE+LOAD for the space, 70 word gap, IDLE+LOAD+SEND for T.
    b = start_cnt;
    send("E", wc);
    send(" ", wc);
    send("T", wc);
    wait_start(b, 20, "e2_seen");
    pulse_done(dc);
    wait_start(b + 1, 200, "t2_seen");
    chk("e_sp_t_spacing", start_cyc - dc, 30 + 2 + 70 + 3);
    chk("t2_pat", 32'(start_pat), 32'b00001);
    pulse_done(dc);
    wait_idle(100, "est_idle");
    chk("est_two_starts", start_cnt - b, 2);

    // Lower case, digit, and an unmappable byte.
    b = start_cnt;
    bb = bad_cnt;
    send("a", wc);
    send("9", wc);
    send("#", wc);
    wait_start(b, 20, "a_seen");
    chk("a_pat", 32'(start_pat), 32'b00010);
    chk("a_len", 32'(start_len), 2);
    pulse_done(dc);
    wait_start(b + 1, 60, "9_seen");
    chk("9_pat", 32'(start_pat), 32'b01111);
    chk("9_len", 32'(start_len), 5);
    pulse_done(dc);
    wait_idle(100, "a9_idle");
    chk("hash_bad", bad_cnt - bb, 1);
    chk("hash_no_start", start_cnt - b, 2);

    // 18 bytes with done withheld: one in flight, 16 buffered, the 18th dropped.
    b = start_cnt;
    ob = ovf_cnt;
    for (int i = 0; i < 18; i++) send("E", wc);
    tick();
    chk("ovf_pulses", ovf_cnt - ob, 1);
    chk("ovf_first_start", start_cnt - b, 1);
    for (int k = 0; k < 17; k++) begin
      wait_start(b + k, 60, "ovf_drain");
      pulse_done(dc);
    end
    wait_idle(100, "ovf_idle");
    repeat (20) tick();
    chk("ovf_held", start_cnt - b, 17);
    chk("ovf_still_one", ovf_cnt - ob, 1);

    // Reset in WAIT_DONE with five bytes queued.
    b = start_cnt;
    for (int i = 0; i < 6; i++) send("T", wc);
    wait_start(b, 20, "rst_seen");
    repeat (2) tick();
    chk("pre_rst_busy", 32'(bus.o_Busy), 1);
    chk("pre_rst_len", 32'(bus.o_Morse_Length), 1);
    rst_n = 1'b0;
    #1;
    chk_outputs_reset("mid_rst");
    tick();
    rst_n = 1'b1;
    b = start_cnt;
    repeat (100) tick();
    chk("post_rst_no_start", start_cnt - b, 0);
    chk("post_rst_busy", 32'(bus.o_Busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
